// File: rtl/tartaruga_pkg.sv
// -----------------------------------------------------------------------------
// tartaruga_pkg
// Shared types and constants for the fetch side of the core.
//   NOP_INSTR_HEX    : canonical NOP (addi x0, x0, 0), returned for faulting fetches
//   IMEM_MAX_LATENCY : largest supported instruction-memory latency
//   imem_entry_t     : one fetch response {addr, instr, fault}
// -----------------------------------------------------------------------------
package tartaruga_pkg;

  localparam logic [31:0] NOP_INSTR_HEX    = 32'h0000_0013;
  localparam int          IMEM_MAX_LATENCY = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        fault;
  } imem_entry_t;

endpackage : tartaruga_pkg

// File: rtl/fetch_rsp_fifo.sv
// -----------------------------------------------------------------------------
// fetch_rsp_fifo
// Synchronous FIFO holding fetch responses until the fetch stage consumes them.
// Ports:
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   clear_i       : drop all contents at the next edge (wins over push/pop)
//   push_i        : write push_data_i at the tail
//   pop_i         : retire the head entry
//   head_o        : current head entry (valid when empty_o is low)
//   full_o        : DEPTH entries held
//   empty_o       : no entries held
//   count_o       : number of entries held
// The caller guarantees no push when full and no pop when empty.
// -----------------------------------------------------------------------------
module fetch_rsp_fifo
  import tartaruga_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = imem_entry_t
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  entry_t                   push_data_i,
  input  logic                     pop_i,
  output entry_t                   head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  entry_t             store_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   count_q;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge value of every other register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      // Storage is cleared so the response outputs read zero out of reset.
      for (int i = 0; i < DEPTH; i++) store_q[i] <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        store_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q          <= next_ptr(wr_ptr_q);
      end
      if (pop_i) rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = store_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;

endmodule : fetch_rsp_fifo

// File: rtl/imem_responder.sv
// -----------------------------------------------------------------------------
// imem_responder
// Instruction-memory responder for the fetch request/response port. Requests
// read the memory at acceptance, travel a LATENCY-deep pipe and land in a
// response FIFO; up to DEPTH responses may be outstanding. A flush discards
// everything outstanding except a request accepted in the flush cycle.
// Ports:
//   clk_i, rst_i               : clock, asynchronous active-high reset
//   req_valid_i / req_ready_o  : request handshake
//   req_addr_i                 : fetch byte address (PC)
//   flush_i                    : drop all outstanding requests and responses
//   rsp_valid_o / rsp_ready_i  : response handshake
//   rsp_addr_o, rsp_instr_o    : answered address and instruction word
//   rsp_fault_o                : request was misaligned or out of range
//   wr_en_i, wr_addr_i, wr_data_i : preload write port
// -----------------------------------------------------------------------------
module imem_responder
  import tartaruga_pkg::*;
#(
  parameter int MEM_WORDS = 4096,
  parameter int LATENCY   = 2,   // 1 .. IMEM_MAX_LATENCY
  parameter int DEPTH     = 4    // power of two, >= LATENCY
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic        flush_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_addr_o,
  output logic [31:0] rsp_instr_o,
  output logic        rsp_fault_o,
  input  logic        wr_en_i,
  input  logic [31:0] wr_addr_i,
  input  logic [31:0] wr_data_i
);

  localparam int          IDX_W       = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int          CNT_W       = $clog2(DEPTH) + 1;
  localparam logic [29:0] MEM_WORDS_W = 30'(MEM_WORDS);

  logic [31:0]      mem [MEM_WORDS];
  logic [CNT_W-1:0] count_q;             // pipe entries + FIFO occupancy
  imem_entry_t      pipe_q [LATENCY];
  logic [LATENCY-1:0] pipe_vld_q;

  logic             accept;
  logic             pop;
  logic             wr_ok;
  logic             rd_fault;
  imem_entry_t      rd_entry;
  imem_entry_t      fifo_head;
  logic             fifo_empty;
  logic             fifo_full;
  logic [CNT_W-1:0] fifo_count;

  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:2] >= MEM_WORDS_W);
  endfunction

  // The counter is purely registered, so ready never depends on this cycle's
  // valid/ready inputs.
  assign req_ready_o = ~rst_i & (count_q < CNT_W'(DEPTH));
  assign accept      = req_valid_i & req_ready_o;
  // A flush kills the head combinationally so nothing transfers this cycle.
  assign rsp_valid_o = ~fifo_empty & ~flush_i;
  assign pop         = rsp_valid_o & rsp_ready_i;

  // Read at acceptance: a same-cycle preload write to this word lands at the
  // edge, so the response carries the old data.
  assign rd_fault = addr_bad(req_addr_i);

  // NOTE: every field gets a value on every path, so no latch is inferred.
  always_comb begin
    rd_entry.addr  = req_addr_i;
    rd_entry.fault = rd_fault;
    rd_entry.instr = rd_fault ? NOP_INSTR_HEX : mem[req_addr_i[IDX_W+1:2]];
  end

  assign wr_ok = wr_en_i & ~addr_bad(wr_addr_i);

  // NOTE: the memory array has no reset; it maps onto RAM and the preloaded
  // image must survive a core reset.
  always_ff @(posedge clk_i) begin
    if (wr_ok) mem[wr_addr_i[IDX_W+1:2]] <= wr_data_i;
  end

  // Latency pipe. Stage 0 always takes this cycle's accept, even under flush:
  // that request is the redirect target. Older stages are killed by flush.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pipe_vld_q <= '0;
      for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      pipe_vld_q[0] <= accept;
      pipe_q[0]     <= rd_entry;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1] & ~flush_i;
        pipe_q[i]     <= pipe_q[i-1];
      end
    end
  end

  // Outstanding counter. Bounding it at DEPTH is what keeps the FIFO from
  // overflowing, so the pipe exit never has to stall.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (flush_i) begin
      count_q <= CNT_W'(accept);
    end else if (accept && !pop) begin
      count_q <= count_q + 1'b1;
    end else if (pop && !accept) begin
      count_q <= count_q - 1'b1;
    end
  end

  // Clear wins over the push: an entry leaving the pipe in the flush cycle is
  // stale.
  fetch_rsp_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (imem_entry_t)
  ) u_rsp_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (flush_i),
    .push_i      (pipe_vld_q[LATENCY-1]),
    .push_data_i (pipe_q[LATENCY-1]),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign rsp_addr_o  = fifo_head.addr;
  assign rsp_instr_o = fifo_head.instr;
  assign rsp_fault_o = fifo_head.fault;

  // FIFO status is implied by count_q; kept on the FIFO for other users.
  logic unused_fifo_status;
  assign unused_fifo_status = ^{fifo_full, fifo_count};

endmodule : imem_responder

// File: tb/tb_imem_responder.sv
// -----------------------------------------------------------------------------
// tb_imem_responder
// Self-checking bench for imem_responder. A transaction-level model (queues of
// pending and deliverable responses plus a word array) predicts ready/valid and
// the head response every cycle; directed sections pin the model with
// hand-computed values, then a randomized phase exercises everything together.
// -----------------------------------------------------------------------------
module tb_imem_responder;

  localparam int MEM_WORDS = 4096;
  localparam int LATENCY   = 2;
  localparam int DEPTH     = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic        flush_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_addr_o;
  logic [31:0] rsp_instr_o;
  logic        rsp_fault_o;
  logic        wr_en_i;
  logic [31:0] wr_addr_i;
  logic [31:0] wr_data_i;

  always #5 clk_i = ~clk_i;

  imem_responder #(
    .MEM_WORDS (MEM_WORDS),
    .LATENCY   (LATENCY),
    .DEPTH     (DEPTH)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr_i),
    .flush_i     (flush_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_addr_o  (rsp_addr_o),
    .rsp_instr_o (rsp_instr_o),
    .rsp_fault_o (rsp_fault_o),
    .wr_en_i     (wr_en_i),
    .wr_addr_i   (wr_addr_i),
    .wr_data_i   (wr_data_i)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;   // number of rising edges seen

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        fault;
    int          due;     // edge at which the response becomes deliverable
  } ment_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        fault;
    int          at_cyc;
  } obs_t;

  typedef struct {
    logic [31:0] addr;
    int          at_edge;
  } acc_t;

  ment_t       pend_q[$];
  ment_t       deliv_q[$];
  logic [31:0] mem_m [MEM_WORDS];
  obs_t        obs_q[$];
  acc_t        acc_q[$];

  bit          d_acc, d_pop, d_flush, d_wr;
  logic [31:0] d_addr, d_wr_addr, d_wr_data;
  int          outstanding;
  bit          exp_ready, exp_valid;

  function automatic bit bad_addr(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) >= 32'(MEM_WORDS));
  endfunction

  function automatic ment_t model_read(input logic [31:0] a, input int due);
    ment_t e;
    e.addr  = a;
    e.fault = bad_addr(a);
    e.instr = e.fault ? NOP : mem_m[a >> 2];
    e.due   = due;
    return e;
  endfunction

  // Compare process: outputs are stable mid-cycle.
  always @(negedge clk_i) begin
    if (rst_i) begin
      check("rst_rsp_valid", 32'(rsp_valid_o), 0);
      check("rst_req_ready", 32'(req_ready_o), 0);
      check("rst_rsp_addr",  rsp_addr_o, 0);
      check("rst_rsp_instr", rsp_instr_o, 0);
      check("rst_rsp_fault", 32'(rsp_fault_o), 0);
      d_acc = 0; d_pop = 0; d_flush = 0; d_wr = 0;
    end else begin
      outstanding = pend_q.size() + deliv_q.size();
      exp_ready   = outstanding < DEPTH;
      exp_valid   = (deliv_q.size() > 0) && !flush_i;
      check("req_ready", 32'(req_ready_o), 32'(exp_ready));
      check("rsp_valid", 32'(rsp_valid_o), 32'(exp_valid));
      if (exp_valid) begin
        check("rsp_addr",  rsp_addr_o,  deliv_q[0].addr);
        check("rsp_instr", rsp_instr_o, deliv_q[0].instr);
        check("rsp_fault", 32'(rsp_fault_o), 32'(deliv_q[0].fault));
      end
      d_acc     = req_valid_i && exp_ready;
      d_addr    = req_addr_i;
      d_pop     = exp_valid && rsp_ready_i;
      d_flush   = flush_i;
      d_wr      = wr_en_i;
      d_wr_addr = wr_addr_i;
      d_wr_data = wr_data_i;
      if (req_valid_i && req_ready_o) acc_q.push_back('{req_addr_i, cyc + 1});
      if (rsp_valid_o && rsp_ready_i)
        obs_q.push_back('{rsp_addr_o, rsp_instr_o, rsp_fault_o, cyc});
    end
  end

  // Model update at each edge from the decisions taken mid-cycle.
  always @(posedge clk_i) begin
    cyc = cyc + 1;
    if (rst_i) begin
      pend_q.delete();
      deliv_q.delete();
    end else begin
      if (d_pop) void'(deliv_q.pop_front());
      if (d_flush) begin
        pend_q.delete();
        deliv_q.delete();
      end
      while (pend_q.size() > 0 && pend_q[0].due <= cyc) deliv_q.push_back(pend_q.pop_front());
      if (d_acc) pend_q.push_back(model_read(d_addr, cyc + LATENCY));
      if (d_wr && !bad_addr(d_wr_addr)) mem_m[d_wr_addr >> 2] = d_wr_data;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    req_valid_i = 1'b0;
    flush_i     = 1'b0;
    wr_en_i     = 1'b0;
  endtask

  task automatic req(input logic [31:0] a);
    req_valid_i = 1'b1;
    req_addr_i  = a;
    tick();
  endtask

  task automatic wait_obs(input int n, input string name);
    int t = 0;
    while (obs_q.size() < n && t < 64) begin
      tick();
      t++;
    end
    check(name, 32'(obs_q.size() >= n), 1);
  endtask

  int base_o, base_a, t;

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) mem_m[i] = '0;
    rst_i = 1'b1; rsp_ready_i = 1'b1;
    req_addr_i = '0; wr_addr_i = '0; wr_data_i = '0;
    idle();
    repeat (3) tick();
    check("reset_ready_low", 32'(req_ready_o), 0);
    check("reset_addr_zero", rsp_addr_o, 0);
    rst_i = 1'b0;
    #1;
    check("ready_after_reset", 32'(req_ready_o), 1);

    // Preload words 0..63; words 0..7 hold 0x1000+i.
    wr_en_i = 1'b1;
    for (int i = 0; i < 64; i++) begin
      wr_addr_i = 32'(4 * i);
      wr_data_i = (i < 8) ? 32'h1000 + 32'(i) : $urandom;
      tick();
    end
    idle();

    // Back-to-back flow
    base_o = obs_q.size(); base_a = acc_q.size();
    for (int i = 0; i < 8; i++) req(32'(4 * i));
    idle();
    wait_obs(base_o + 8, "b2b_count");
    if (obs_q.size() >= base_o + 8 && acc_q.size() > base_a) begin
      check("b2b_latency", 32'(obs_q[base_o].at_cyc - acc_q[base_a].at_edge), 2);
      for (int i = 0; i < 8; i++) begin
        check("b2b_instr", obs_q[base_o + i].instr, 32'h1000 + 32'(i));
        check("b2b_back_to_back", 32'(obs_q[base_o + i].at_cyc - obs_q[base_o].at_cyc), 32'(i));
      end
    end

    // Backpressure
    rsp_ready_i = 1'b0;
    base_o = obs_q.size(); base_a = acc_q.size();
    for (int i = 0; i < 6; i++) req(32'(4 * i));
    idle();
    check("bp_accepted", 32'(acc_q.size() - base_a), 4);
    check("bp_ready_low", 32'(req_ready_o), 0);
    tick(); tick();
    check("bp_ready_still_low", 32'(req_ready_o), 0);
    rsp_ready_i = 1'b1;
    wait_obs(base_o + 4, "bp_count");
    if (obs_q.size() >= base_o + 4)
      for (int i = 0; i < 4; i++) check("bp_order", obs_q[base_o + i].addr, 32'(4 * i));
    tick();
    check("bp_ready_back", 32'(req_ready_o), 1);

    // Flush with redirect
    rsp_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) req(32'h20 + 32'(4 * i));
    idle();
    tick();
    base_o = obs_q.size();
    flush_i = 1'b1;
    req(32'h40);
    idle();
    rsp_ready_i = 1'b1;
    wait_obs(base_o + 1, "flush_count");
    if (obs_q.size() > base_o) begin
      check("flush_redirect_addr", obs_q[base_o].addr, 32'h40);
      check("flush_redirect_latency", 32'(obs_q[base_o].at_cyc - acc_q[$].at_edge), 2);
    end
    repeat (4) tick();
    check("flush_no_stale", 32'(obs_q.size() - base_o), 1);

    // Faults and ignored misaligned preload
    base_o = obs_q.size();
    req(32'h2);
    req(32'(4 * MEM_WORDS));
    idle();
    wr_en_i = 1'b1; wr_addr_i = 32'h2; wr_data_i = 32'hDEAD_BEEF;
    tick();
    idle();
    req(32'h0);
    idle();
    wait_obs(base_o + 3, "fault_count");
    if (obs_q.size() >= base_o + 3) begin
      check("fault_misaligned", 32'(obs_q[base_o].fault), 1);
      check("fault_misaligned_nop", obs_q[base_o].instr, NOP);
      check("fault_range_addr", obs_q[base_o + 1].addr, 32'h4000);
      check("fault_range", 32'(obs_q[base_o + 1].fault), 1);
      check("fault_range_nop", obs_q[base_o + 1].instr, NOP);
      check("misaligned_write_ignored", obs_q[base_o + 2].instr, 32'h1000);
      check("aligned_no_fault", 32'(obs_q[base_o + 2].fault), 0);
    end

    // Write/read collision
    base_o = obs_q.size();
    wr_en_i = 1'b1; wr_addr_i = 32'h10; wr_data_i = 32'hAAAA;
    tick();
    wr_data_i = 32'hBBBB;
    req(32'h10);
    wr_en_i = 1'b0;
    req(32'h10);
    idle();
    wait_obs(base_o + 2, "collide_count");
    if (obs_q.size() >= base_o + 2) begin
      check("collide_old_data", obs_q[base_o].instr, 32'hAAAA);
      check("collide_new_data", obs_q[base_o + 1].instr, 32'hBBBB);
    end

    // Mid-operation reset: two queued, one in flight
    rsp_ready_i = 1'b0;
    for (int i = 5; i < 8; i++) req(32'(4 * i));
    idle();
    tick();
    check("mr_queued_before", 32'(rsp_valid_o), 1);
    rst_i = 1'b1;
    #1;
    check("mr_valid_dropped", 32'(rsp_valid_o), 0);
    check("mr_ready_low", 32'(req_ready_o), 0);
    tick(); tick();
    rst_i = 1'b0;
    base_o = obs_q.size(); base_a = acc_q.size();
    for (int i = 0; i < 5; i++) req(32'(4 * i));
    idle();
    check("mr_accepted", 32'(acc_q.size() - base_a), 4);
    check("mr_no_old_rsp", 32'(obs_q.size() - base_o), 0);
    rsp_ready_i = 1'b1;
    wait_obs(base_o + 4, "mr_count");
    if (obs_q.size() >= base_o + 4)
      for (int i = 0; i < 4; i++) begin
        check("mr_addr", obs_q[base_o + i].addr, 32'(4 * i));
        check("mr_mem_kept", obs_q[base_o + i].instr, 32'h1000 + 32'(i));
      end

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      int r;
      r = $urandom_range(0, 15);
      req_valid_i = ($urandom_range(0, 3) != 0);
      if (r == 0)      req_addr_i = 32'(4 * $urandom_range(0, 63) + $urandom_range(1, 3));
      else if (r == 1) req_addr_i = 32'(4 * MEM_WORDS + 4 * $urandom_range(0, 1000));
      else             req_addr_i = 32'(4 * $urandom_range(0, 63));
      rsp_ready_i = ($urandom_range(0, 2) != 0);
      flush_i     = ($urandom_range(0, 31) == 0);
      wr_en_i     = ($urandom_range(0, 7) == 0);
      wr_addr_i   = 32'(4 * $urandom_range(0, 63) + (($urandom_range(0, 9) == 0) ? 1 : 0));
      wr_data_i   = $urandom;
      tick();
    end
    idle();
    rsp_ready_i = 1'b1;
    t = 0;
    while ((pend_q.size() + deliv_q.size()) > 0 && t < 64) begin
      tick();
      t++;
    end
    check("drain_empty", 32'(pend_q.size() + deliv_q.size()), 0);
    tick();
    check("drain_ready", 32'(req_ready_o), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_imem_responder
